// File: rtl/hidden_cpu_pkg.sv
// Shared constants for the hidden CPU: instruction format, program-store depth,
// the NOP encoding and the fetch-unit FSM state encodings.
package hidden_cpu_pkg;

  localparam int INSTR_W = 6;
  localparam int DEPTH   = 16;

  localparam logic [5:0] NOP_INSTR = 6'b000000;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

endpackage

// File: rtl/prog_mem.sv
// Program store: DEPTH x INSTR_W register file, synchronous write, combinational read.
// No reset on the array; no backpressure, a write is accepted every cycle wr_en is high.
module prog_mem #(
  parameter int DEPTH   = 16,
  parameter int INSTR_W = 6,
  parameter int AW      = 4
) (
  input  logic               clk,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [INSTR_W-1:0] wr_data,
  input  logic [AW-1:0]      rd_addr,
  output logic [INSTR_W-1:0] rd_data
);

  logic [INSTR_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: loads a program into prog_mem, then serves fetches with 1-cycle latency.
// Never stalls: every fetch_req gets exactly one response; writes beyond DEPTH are dropped and flagged.
module instr_fetch
  import hidden_cpu_pkg::*;
#(
  parameter int DEPTH   = hidden_cpu_pkg::DEPTH,
  parameter int INSTR_W = hidden_cpu_pkg::INSTR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_en,
  input  logic               load_valid,
  input  logic [INSTR_W-1:0] load_data,
  input  logic [7:0]         pc,
  input  logic               fetch_req,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic [4:0]         prog_len,
  output logic               loading,
  output logic               overflow
);

  localparam int                 AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0]         DEPTH_L = 5'(DEPTH);
  localparam logic [INSTR_W-1:0] NOP_W   = INSTR_W'(NOP_INSTR);

  logic [1:0]         state;
  logic [AW-1:0]      wr_ptr;
  logic               full;
  logic               wr_en;
  logic [INSTR_W-1:0] rd_data;
  logic [4:0]         pc_idx;
  logic               pc_hit;
  logic               unused_pc_hi;

  // Upper pc bits are deliberately ignored so the program wraps every 16 words.
  assign unused_pc_hi = ^pc[7:4];
  assign pc_idx       = {1'b0, pc[3:0]};
  assign pc_hit       = (state == ST_RUN) && (pc_idx < prog_len);

  assign full    = (prog_len == DEPTH_L);
  assign wr_en   = (state == ST_LOAD) && load_valid && !full;
  assign loading = (state == ST_LOAD);

  prog_mem #(
    .DEPTH   (DEPTH),
    .INSTR_W (INSTR_W),
    .AW      (AW)
  ) u_prog_mem (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_data (load_data),
    .rd_addr (pc[AW-1:0]),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_EMPTY;
      wr_ptr      <= '0;
      prog_len    <= '0;
      overflow    <= 1'b0;
      instr       <= NOP_W;
      instr_valid <= 1'b0;
    end else begin
      instr_valid <= fetch_req;
      if (fetch_req) begin
        instr <= pc_hit ? rd_data : NOP_W;
      end

      case (state)
        ST_LOAD: begin
          if (wr_en) begin
            wr_ptr   <= wr_ptr + AW'(1);
            prog_len <= prog_len + 5'd1;
          end else if (load_valid) begin
            overflow <= 1'b1;
          end
          // A write on the exit cycle still counts towards having a program.
          if (!load_en) begin
            state <= ((prog_len != 5'd0) || wr_en) ? ST_RUN : ST_EMPTY;
          end
        end
        default: begin
          if (load_en) begin
            state    <= ST_LOAD;
            wr_ptr   <= '0;
            prog_len <= '0;
            overflow <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch: reset, load/fetch, bounds/wrap,
// overflow, back-to-back fetch and reset during a load.
module tb_instr_fetch;

  logic       clk;
  logic       rst;
  logic       load_en;
  logic       load_valid;
  logic [5:0] load_data;
  logic [7:0] pc;
  logic       fetch_req;
  logic [5:0] instr;
  logic       instr_valid;
  logic [4:0] prog_len;
  logic       loading;
  logic       overflow;

  int n_cmp = 0;
  int n_err = 0;

  instr_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .load_en     (load_en),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .pc          (pc),
    .fetch_req   (fetch_req),
    .instr       (instr),
    .instr_valid (instr_valid),
    .prog_len    (prog_len),
    .loading     (loading),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst        = 1'b1;
    load_en    = 1'b1;
    load_valid = 1'b0;
    load_data  = 6'h00;
    pc         = 8'h00;
    fetch_req  = 1'b0;

    // Reset held for two cycles with load_en high.
    tick();
    tick();
    chk("rst_prog_len", 32'(prog_len), 32'd0);
    chk("rst_loading", 32'(loading), 32'd0);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", 32'(instr), 32'h00);
    chk("rst_overflow", 32'(overflow), 32'd0);

    // Enter LOAD; the strobe on the entry cycle must be ignored.
    rst        = 1'b0;
    load_valid = 1'b1;
    load_data  = 6'h3F;
    tick();
    chk("enter_loading", 32'(loading), 32'd1);
    chk("enter_ignore_wr", 32'(prog_len), 32'd0);

    load_data = 6'h11;
    tick();
    load_data = 6'h22;
    fetch_req = 1'b1;
    pc        = 8'h00;
    tick();
    chk("load_fetch_nop", 32'(instr), 32'h00);
    chk("load_fetch_vld", 32'(instr_valid), 32'd1);
    fetch_req = 1'b0;
    load_data = 6'h33;
    tick();
    chk("load_prog_len3", 32'(prog_len), 32'd3);

    // Leave LOAD -> RUN; no fetch so instr_valid drops and instr holds.
    load_valid = 1'b0;
    load_en    = 1'b0;
    tick();
    chk("run_loading", 32'(loading), 32'd0);
    chk("idle_vld", 32'(instr_valid), 32'd0);
    chk("idle_hold", 32'(instr), 32'h00);

    fetch_req = 1'b1;
    pc        = 8'd1;
    tick();
    chk("fetch_pc1", 32'(instr), 32'h22);
    chk("fetch_pc1_vld", 32'(instr_valid), 32'd1);
    chk("fetch_prog_len", 32'(prog_len), 32'd3);

    pc = 8'd5;
    tick();
    chk("oob_pc5", 32'(instr), 32'h00);
    pc = 8'h12;
    tick();
    chk("wrap_pc12", 32'(instr), 32'h33);
    fetch_req = 1'b0;
    tick();
    chk("hold_vld", 32'(instr_valid), 32'd0);
    chk("hold_instr", 32'(instr), 32'h33);

    // Back-to-back fetches pc 0..3.
    fetch_req = 1'b1;
    pc = 8'd0; tick(); chk("b2b_0", 32'(instr), 32'h11); chk("b2b_0_vld", 32'(instr_valid), 32'd1);
    pc = 8'd1; tick(); chk("b2b_1", 32'(instr), 32'h22); chk("b2b_1_vld", 32'(instr_valid), 32'd1);
    pc = 8'd2; tick(); chk("b2b_2", 32'(instr), 32'h33); chk("b2b_2_vld", 32'(instr_valid), 32'd1);
    pc = 8'd3; tick(); chk("b2b_3", 32'(instr), 32'h00); chk("b2b_3_vld", 32'(instr_valid), 32'd1);
    fetch_req = 1'b0;

    // Overflow: 17 writes into a 16-entry store.
    load_en = 1'b1;
    tick();
    chk("ovf_enter_len", 32'(prog_len), 32'd0);
    load_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      load_data = 6'(6'h20 + i);
      tick();
    end
    load_valid = 1'b0;
    chk("ovf_prog_len", 32'(prog_len), 32'd16);
    chk("ovf_flag", 32'(overflow), 32'd1);
    load_en = 1'b0;
    tick();
    fetch_req = 1'b1;
    pc = 8'd0;  tick(); chk("ovf_mem0", 32'(instr), 32'h20);
    pc = 8'd15; tick(); chk("ovf_mem15", 32'(instr), 32'h2F);
    fetch_req = 1'b0;
    chk("ovf_sticky", 32'(overflow), 32'd1);
    load_en = 1'b1;
    tick();
    chk("ovf_clear", 32'(overflow), 32'd0);
    chk("ovf_reload_len", 32'(prog_len), 32'd0);

    // Reset after 2 of 4 writes aborts the load.
    load_valid = 1'b1;
    load_data = 6'h0A; tick();
    load_data = 6'h0B; tick();
    chk("mid_len2", 32'(prog_len), 32'd2);
    rst = 1'b1;
    tick();
    chk("mid_rst_loading", 32'(loading), 32'd0);
    chk("mid_rst_len", 32'(prog_len), 32'd0);
    rst        = 1'b0;
    load_en    = 1'b0;
    load_valid = 1'b0;
    tick();
    chk("mid_empty_loading", 32'(loading), 32'd0);
    fetch_req = 1'b1;
    pc        = 8'd0;
    tick();
    chk("mid_fetch_nop", 32'(instr), 32'h00);
    chk("mid_fetch_vld", 32'(instr_valid), 32'd1);
    fetch_req = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
